// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin CPU/host data-memory arbiter with halt priority, host lock and one-cycle read return.
// Ports: clk_i/rst_i clock and async active-high reset; do_halt_i gives the host absolute priority;
//   cpu_* and host_* are request channels (req/we/addr/wdata in, gnt/rvalid/rdata out, cpu_stall_o, host_lock_i);
//   mem_* drives a single-port memory whose mem_rdata_i returns one cycle after a read strobe.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              do_halt_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_stall_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic              host_lock_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, CPU, HOST} owner_e;
  owner_e owner_q, owner_d;
  logic cpu_pend_q, cpu_pend_d, host_pend_q, host_pend_d;
  // Host wins on halt, while holding a lock, when alone, or on a tie after a CPU grant (IDLE acts as HOST).
  always_comb begin
    host_gnt_o = ~rst_i & host_req_i & (do_halt_i | (owner_q == HOST & host_lock_i) | ~cpu_req_i | owner_q == CPU);
    cpu_gnt_o = ~rst_i & cpu_req_i & ~do_halt_i & ~host_gnt_o;
    cpu_stall_o = ~rst_i & cpu_req_i & ~cpu_gnt_o;
    mem_en_o = host_gnt_o | cpu_gnt_o;
    mem_we_o = host_gnt_o ? host_we_i : cpu_gnt_o & cpu_we_i;
    mem_addr_o = host_gnt_o ? host_addr_i : cpu_gnt_o ? cpu_addr_i : '0;
    mem_wdata_o = host_gnt_o ? host_wdata_i : cpu_gnt_o ? cpu_wdata_i : '0;
    owner_d = host_gnt_o ? HOST : cpu_gnt_o ? CPU : owner_q;
    cpu_pend_d = cpu_gnt_o & ~cpu_we_i;
    host_pend_d = host_gnt_o & ~host_we_i;
    cpu_rvalid_o = ~rst_i & cpu_pend_q;
    host_rvalid_o = ~rst_i & host_pend_q;
    cpu_rdata_o = cpu_rvalid_o ? mem_rdata_i : '0;
    host_rdata_o = host_rvalid_o ? mem_rdata_i : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q <= IDLE;
      cpu_pend_q <= 1'b0;
      host_pend_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      cpu_pend_q <= cpu_pend_d;
      host_pend_q <= host_pend_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a behavioural arbitration/memory model.
module tb_dmem_arbiter;
  logic        clk_i = 0;
  logic        rst_i = 1;
  logic        do_halt_i = 0;
  logic        cpu_req_i = 0, cpu_we_i = 0;
  logic [7:0]  cpu_addr_i = 0;
  logic [15:0] cpu_wdata_i = 0;
  logic        cpu_gnt_o, cpu_stall_o, cpu_rvalid_o;
  logic [15:0] cpu_rdata_o;
  logic        host_req_i = 0, host_we_i = 0, host_lock_i = 0;
  logic [7:0]  host_addr_i = 0;
  logic [15:0] host_wdata_i = 0;
  logic        host_gnt_o, host_rvalid_o;
  logic [15:0] host_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [15:0] mem_rdata_i = 0;
  logic        pre_en = 0;
  logic [7:0]  pre_a = 0;
  logic [15:0] pre_d = 0;
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  int total = 0, bad = 0;
  int owner = 0;
  int pend_who = 0;
  logic [15:0] pend_data = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .do_halt_i(do_halt_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_stall_o(cpu_stall_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_lock_i(host_lock_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
      else mem_rdata_i <= mem[mem_addr_o];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cpu_gnt"}, 32'(cpu_gnt_o), 0);
    chk({tag, "_host_gnt"}, 32'(host_gnt_o), 0);
    chk({tag, "_stall"}, 32'(cpu_stall_o), 0);
    chk({tag, "_mem_en"}, 32'(mem_en_o), 0);
    chk({tag, "_mem_we"}, 32'(mem_we_o), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr_o), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata_o), 0);
    chk({tag, "_rvalids"}, {30'd0, cpu_rvalid_o, host_rvalid_o}, 0);
    chk({tag, "_rdatas"}, {cpu_rdata_o, host_rdata_o}, 0);
  endtask

  // One arbitration cycle: drive, check against the model, clock, then advance the model.
  task automatic step(input logic halt, input logic hr, input logic hw, input logic hl, input logic [7:0] ha,
                      input logic [15:0] hd, input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cd);
    int w;
    do_halt_i = halt; host_req_i = hr; host_we_i = hw; host_lock_i = hl; host_addr_i = ha; host_wdata_i = hd;
    cpu_req_i = cr; cpu_we_i = cw; cpu_addr_i = ca; cpu_wdata_i = cd;
    #1;
    if (halt) w = hr ? 2 : 0;
    else if (owner == 2 && hl && hr) w = 2;
    else if (cr && !hr) w = 1;
    else if (hr && !cr) w = 2;
    else if (cr && hr) w = (owner == 1) ? 2 : 1;
    else w = 0;
    chk("cpu_gnt", 32'(cpu_gnt_o), 32'(w == 1));
    chk("host_gnt", 32'(host_gnt_o), 32'(w == 2));
    chk("cpu_stall", 32'(cpu_stall_o), 32'(cr && w != 1));
    chk("mem_en", 32'(mem_en_o), 32'(w != 0));
    chk("mem_we", 32'(mem_we_o), 32'(w == 1 ? cw : w == 2 ? hw : 1'b0));
    if (w != 0) begin
      chk("mem_addr", 32'(mem_addr_o), 32'(w == 1 ? ca : ha));
      chk("mem_wdata", 32'(mem_wdata_o), 32'(w == 1 ? cd : hd));
    end
    chk("cpu_rvalid", 32'(cpu_rvalid_o), 32'(pend_who == 1));
    chk("cpu_rdata", 32'(cpu_rdata_o), pend_who == 1 ? 32'(pend_data) : 0);
    chk("host_rvalid", 32'(host_rvalid_o), 32'(pend_who == 2));
    chk("host_rdata", 32'(host_rdata_o), pend_who == 2 ? 32'(pend_data) : 0);
    @(posedge clk_i);
    pend_who = 0;
    if (w != 0) begin
      owner = w;
      if (w == 1 ? cw : hw) ref_mem[w == 1 ? ca : ha] = (w == 1 ? cd : hd);
      else begin
        pend_who = w;
        pend_data = ref_mem[w == 1 ? ca : ha];
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cpu_req_i = 1; host_req_i = 1; host_we_i = 1;
    #1;
    chk_zero("reset");
    pre_en = 1;
    for (int i = 0; i < 256; i++) begin
      pre_a = 8'(i);
      pre_d = (i == 0) ? 16'd30000 : (i == 1) ? 16'd10 : 16'($urandom);
      ref_mem[i] = pre_d;
      @(posedge clk_i);
      #1;
    end
    pre_en = 0;
    chk_zero("reset_hold");
    rst_i = 0;
    // Tie sequence straight out of reset: CPU, HOST, CPU, HOST.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'(10 + i), 0, 1, 0, 8'(20 + i), 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'd1, 0);
    idle();
    // Host lock holds ownership, release hands the tie to the CPU.
    step(0, 1, 0, 0, 8'd5, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 8'(30 + i), 16'(100 + i), 1, 0, 8'd7, 0);
    step(0, 1, 0, 0, 8'd8, 0, 1, 0, 8'd7, 0);
    // Lock with CPU as owner is ignored.
    step(0, 1, 0, 1, 8'd9, 0, 1, 0, 8'd7, 0);
    step(0, 1, 0, 1, 8'd9, 0, 1, 0, 8'd7, 0);
    // Halt: host reads addr 0 every cycle, CPU locked out.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 8'd0, 0, 1, 0, 8'd3, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'd3, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'd3, 0);
    // Host write then CPU read of the same word.
    step(0, 1, 1, 0, 8'd2, 16'd245, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'd2, 0);
    idle();
    for (int i = 0; i < 400; i++)
      step(($urandom % 8) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom % 16), 16'($urandom),
           1'($urandom), 1'($urandom), 8'($urandom % 16), 16'($urandom));
    // Reset mid-cycle after a CPU read grant.
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'd1, 0);
    chk("pre_reset_rvalid", 32'(cpu_rvalid_o), 1);
    cpu_req_i = 1; host_req_i = 1;
    rst_i = 1;
    #1;
    chk_zero("mid_reset");
    owner = 0;
    pend_who = 0;
    @(posedge clk_i);
    #1;
    rst_i = 0;
    step(0, 1, 0, 0, 8'd4, 0, 1, 0, 8'd6, 0);
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of data memory.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 do_halt  input  1  CPU halted; host gets absolute priority.
REQ-006 cpu_req / cpu_we  input  1 / 1  CPU memory-stage access request / write enable.
REQ-007 cpu_addr / cpu_wdata  input  ADDR_W / DATA_W  CPU address / write data.
REQ-008 cpu_gnt / cpu_stall  output  1 / 1  CPU access accepted this cycle / cpu_req & ~cpu_gnt.
REQ-009 cpu_rvalid / cpu_rdata  output  1 / DATA_W  CPU read data valid / read data.
REQ-010 host_req / host_we / host_lock  input  1 / 1 / 1  host (loader/debug) request / write enable / hold ownership.
REQ-011 host_addr / host_wdata  input  ADDR_W / DATA_W  host address / write data.
REQ-012 host_gnt / host_rvalid / host_rdata  output  1 / 1 / DATA_W  host accepted / read valid / read data.
REQ-013 mem_en / mem_we  output  1 / 1  memory access strobe / write.
REQ-014 mem_addr / mem_wdata  output  ADDR_W / DATA_W  memory address / write data.
REQ-015 mem_rdata  input  DATA_W  memory read data, valid one cycle after a read strobe.

Function
REQ-016 SHALL grant at most one requester per cycle; grant combinational from current inputs and state; at most one access per cycle.
REQ-017 SHALL hold state register owner in {IDLE, CPU, HOST}: the last granted requester (IDLE after reset).
REQ-018 Priority: do_halt=1 -> host only, cpu_gnt=0; owner=HOST & host_lock & host_req -> host; else only one request -> that one; both -> requester that is not owner (IDLE counts as HOST, so CPU wins first tie).
REQ-019 On a grant, SHALL drive mem_en=1, mem_we/mem_addr/mem_wdata from the winner in the same cycle; mem_en=0 and mem_we=0 with no grant.
REQ-020 owner SHALL update to the winner at the clock edge of each grant; unchanged in cycles without a grant.
REQ-021 Granted read SHALL produce winner's rvalid=1 for exactly one cycle on the next cycle, rdata=mem_rdata that cycle; pending-read tag register records the winner.
REQ-022 Writes SHALL produce no rvalid; write completes in the grant cycle.
REQ-023 rdata outputs SHALL be 0 when corresponding rvalid=0.
REQ-024 Back-to-back grants SHALL be supported: read in cycle N and access in N+1 both issued; rvalid for N in N+1 unaffected.
REQ-025 Losing requester SHALL keep req and payload stable until granted; arbiter need not buffer.
REQ-026 host_lock with owner≠HOST SHALL have no effect; lock released -> normal round-robin resumes next cycle.
REQ-027 do_halt falling SHALL take effect the same cycle (combinational).

Reset
REQ-028 rst=1 SHALL asynchronously force owner=IDLE and clear pending-read tags.
REQ-029 During rst=1, all outputs SHALL be 0 (grants, rvalids, rdata, mem_*), regardless of requests.
REQ-030 A read granted in the cycle before reset SHALL produce no rvalid after reset release.
REQ-031 First cycle after rst falls, normal arbitration SHALL apply.

Verification
REQ-032 CPU read only: cpu_req=1, cpu_we=0, cpu_addr=1, memory[1]=10 -> cpu_gnt=1, mem_en=1, mem_addr=1 cycle N; cpu_rvalid=1, cpu_rdata=10 cycle N+1.
REQ-033 Both requesting 4 cycles after reset -> grants CPU, HOST, CPU, HOST; cpu_stall=1 in cycles 2 and 4.
REQ-034 host_lock=1, host and CPU requesting 3 cycles after host grant -> host granted all 3 cycles, cpu_stall=1; lock drop -> CPU granted next cycle.
REQ-035 do_halt=1, both request; host reads addr 0 holding 30000 -> host_gnt every cycle, cpu_gnt=0, host_rdata=30000 one cycle later.
REQ-036 Host writes 245 to addr 2, CPU reads addr 2 next cycle -> mem_we=1 then 0; cpu_rdata=245.
REQ-037 rst asserted mid-cycle after a CPU read grant -> outputs 0 immediately, no cpu_rvalid after release, first tie goes to CPU.
